bus_xfer_engine: RTL and testbench
==================================

BUS_XFER_ENGINE -- requirements
Module: bus_xfer_engine

Interface
- REQ-001 SHALL have parameter WIDTH, default 4, meaning the register and bus width in bits.
- REQ-002 SHALL have parameter ADDR_W, default 2, meaning the register index width; register count is 2**ADDR_W.
- REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
- REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
- REQ-005 SHALL have port cmd_valid  input  1  command offered.
- REQ-006 SHALL have port cmd_ready  output  1  engine can accept a command.
- REQ-007 SHALL have port cmd_op  input  2  opcode: 00 MOVE, 01 LOAD, 10 SWAP, 11 reserved.
- REQ-008 SHALL have port cmd_src  input  ADDR_W  source register index.
- REQ-009 SHALL have port cmd_dst  input  ADDR_W  destination register index.
- REQ-010 SHALL have port cmd_imm  input  WIDTH  immediate value for LOAD.
- REQ-011 SHALL have port bus  output  WIDTH  internal shared bus value; all-zero when undriven; no tri-state.
- REQ-012 SHALL have port bus_drv  output  1  high while a source drives bus.
- REQ-013 SHALL have port done  output  1  one-cycle pulse on completion of a legal command.
- REQ-014 SHALL have port err  output  1  one-cycle pulse on completion of an illegal command.
- REQ-015 SHALL have port rd_addr  input  ADDR_W  debug read index.
- REQ-016 SHALL have port rd_data  output  WIDTH  combinational read of register rd_addr.

Function
- REQ-017 SHALL accept a command at a rising edge where cmd_valid and cmd_ready are both high, capturing op, src, dst and imm at that edge.
- REQ-018 SHALL drive cmd_ready high only in state IDLE; commands offered in other states are ignored.
- REQ-019 SHALL implement states IDLE, DRV1, DRV2, DRV3, DONE and ERR.
- REQ-020 MOVE: IDLE->DRV1 at accept; in DRV1 bus=R[src], bus_drv=1; at edge ending DRV1, R[dst]<=bus; ->DONE.
- REQ-021 LOAD: as MOVE, but in DRV1 bus=captured imm.
- REQ-022 DONE SHALL last one cycle with done=1, then ->IDLE; a legal MOVE/LOAD occupies 3 cycles (accept edge to next accept edge).
- REQ-023 src==dst on MOVE SHALL be a no-op on register contents with unchanged timing.
- REQ-024 Opcode 11, and 10 when swap is compiled out, SHALL go IDLE->ERR with err=1 for one cycle, no register write, bus_drv=0, then ->IDLE.
- REQ-025 Outside drive states bus SHALL be 0 and bus_drv 0; done and err SHALL never be high together.
- REQ-026 rd_data SHALL reflect a register write from the cycle following the writing edge.

Reset
- REQ-027 Asserting rst SHALL immediately force all registers to 0, state IDLE, bus 0, bus_drv 0, done 0, err 0; cmd_ready goes high one edge after rst deasserts.
- REQ-028 Reset during DRV1..DRV3 SHALL abort the command; the edge coinciding with rst high SHALL perform no register write.

Configuration
- REQ-029 Macro XFER_SWAP_EN SHALL, when defined, enable SWAP: DRV1 bus=R[src] latched into internal tmp; DRV2 bus=R[dst], R[src]<=bus; DRV3 bus=tmp, R[dst]<=bus; then DONE (5 cycles total).
- REQ-030 Without XFER_SWAP_EN the tmp register and DRV2/DRV3 SHALL be absent and opcode 10 SHALL follow REQ-024.
- REQ-031 SWAP with src==dst SHALL leave contents unchanged with full SWAP timing.

Verification (WIDTH=4, ADDR_W=2)
- REQ-032 Reset, LOAD imm=4'hA dst=0 -> bus=A with bus_drv=1 for one cycle, done pulse 2 cycles after accept, rd_data(0)=A.
- REQ-033 R0=A, MOVE src=0 dst=1 -> bus=A in DRV1, R1=A, R0 still A, cmd_ready low for 2 cycles.
- REQ-034 Opcode 11 -> err=1 for one cycle, done=0, bus_drv=0, all registers unchanged.
- REQ-035 With XFER_SWAP_EN, R0=A, R1=5, SWAP 0,1 -> bus sequence A,5,A, final R0=5, R1=A, done 4 cycles after accept; without the macro -> err pulse.
- REQ-036 Assert rst mid-DRV1 of MOVE 0->1 with R0=A -> all registers 0, IDLE, no done/err pulse.
- REQ-037 cmd_valid held high with back-to-back LOADs -> one accept every 3 cycles, no command lost or duplicated.

Source files
------------

// File: rtl/bus_xfer_engine.sv
// Register-file transfer engine: MOVE/LOAD (and SWAP) over a single shared internal bus.
// Optional feature: define XFER_SWAP_EN to build the SWAP opcode (tmp register, DRV2/DRV3).
module bus_xfer_engine #(
  parameter int WIDTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_src,
  input  logic [ADDR_W-1:0] cmd_dst,
  input  logic [WIDTH-1:0]  cmd_imm,
  output logic [WIDTH-1:0]  bus,
  output logic              bus_drv,
  output logic              done,
  output logic              err,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  localparam int NREG = 2 ** ADDR_W;
  localparam logic [1:0] OP_MOVE = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_SWAP = 2'b10;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    DRV1 = 3'd1,
`ifdef XFER_SWAP_EN
    DRV2 = 3'd2,
    DRV3 = 3'd3,
`endif
    DONE = 3'd4,
    ERR  = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic                init_q;
  logic [1:0]          op_q;
  logic [ADDR_W-1:0]   src_q, dst_q;
  logic [WIDTH-1:0]    imm_q;
  logic [WIDTH-1:0]    regs_q [NREG];
  logic [WIDTH-1:0]    bus_s;
  logic                bus_drv_s, done_s, err_s, ready_s, accept_s;
  logic                wr_en_s;
  logic [ADDR_W-1:0]   wr_addr_s;
`ifdef XFER_SWAP_EN
  logic [WIDTH-1:0]    tmp_q;
  logic                tmp_ld_s;
`endif

  // init_q keeps cmd_ready low until the first edge after reset release
  assign ready_s  = init_q && (state_q == IDLE);
  assign accept_s = cmd_valid && ready_s;

  always_comb begin
    state_d   = state_q;
    bus_s     = '0;
    bus_drv_s = 1'b0;
    done_s    = 1'b0;
    err_s     = 1'b0;
    wr_en_s   = 1'b0;
    wr_addr_s = dst_q;
`ifdef XFER_SWAP_EN
    tmp_ld_s  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          case (cmd_op)
            OP_MOVE, OP_LOAD: state_d = DRV1;
`ifdef XFER_SWAP_EN
            OP_SWAP:          state_d = DRV1;
`endif
            default:          state_d = ERR;
          endcase
        end else begin
          state_d = IDLE;
        end
      end
      DRV1: begin
        bus_drv_s = 1'b1;
        bus_s     = (op_q == OP_LOAD) ? imm_q : regs_q[src_q];
`ifdef XFER_SWAP_EN
        if (op_q == OP_SWAP) begin
          tmp_ld_s = 1'b1;
          state_d  = DRV2;
        end else begin
          wr_en_s  = 1'b1;
          state_d  = DONE;
        end
`else
        wr_en_s   = 1'b1;
        state_d   = DONE;
`endif
      end
`ifdef XFER_SWAP_EN
      DRV2: begin
        bus_drv_s = 1'b1;
        bus_s     = regs_q[dst_q];
        wr_en_s   = 1'b1;
        wr_addr_s = src_q;
        state_d   = DRV3;
      end
      DRV3: begin
        bus_drv_s = 1'b1;
        bus_s     = tmp_q;
        wr_en_s   = 1'b1;
        state_d   = DONE;
      end
`endif
      DONE: begin
        done_s  = 1'b1;
        state_d = IDLE;
      end
      ERR: begin
        err_s   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      init_q  <= 1'b0;
      op_q    <= 2'b00;
      src_q   <= '0;
      dst_q   <= '0;
      imm_q   <= '0;
    end else begin
      state_q <= state_d;
      init_q  <= 1'b1;
      if (accept_s) begin
        op_q  <= cmd_op;
        src_q <= cmd_src;
        dst_q <= cmd_dst;
        imm_q <= cmd_imm;
      end
    end
  end

  // Reset dominates, so an edge coinciding with rst high never writes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (wr_en_s) begin
      regs_q[wr_addr_s] <= bus_s;
    end
  end

`ifdef XFER_SWAP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmp_q <= '0;
    end else if (tmp_ld_s) begin
      tmp_q <= bus_s;
    end
  end
`endif

  assign cmd_ready = ready_s;
  assign bus       = bus_s;
  assign bus_drv   = bus_drv_s;
  assign done      = done_s;
  assign err       = err_s;
  assign rd_data   = regs_q[rd_addr];

endmodule

// File: tb/tb_bus_xfer_engine.sv
// Scoreboard bench for bus_xfer_engine: stimulus queues expected bus/done/err events,
// a negedge monitor pops and compares them (value and cycle).
module tb_bus_xfer_engine;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [1:0] cmd_src = 2'b00;
  logic [1:0] cmd_dst = 2'b00;
  logic [3:0] cmd_imm = 4'h0;
  logic [3:0] bus;
  logic       bus_drv, done, err;
  logic [1:0] rd_addr = 2'b00;
  logic [3:0] rd_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int         kind;   // 0 bus, 1 done, 2 err
    logic [3:0] val;
    int         at;
  } ev_t;
  ev_t exp_q[$];

  bus_xfer_engine #(.WIDTH(4), .ADDR_W(2)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_imm(cmd_imm),
    .bus(bus), .bus_drv(bus_drv), .done(done), .err(err),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic pop_cmp(input int kind, input int val);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: kind %0d value %0d expected none (cycle %0d)", kind, val, cyc);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", kind, e.kind);
      chk("event_value", val, int'(e.val));
      chk("event_cycle", cyc, e.at);
    end
  endtask

  // Monitor: compares every observed bus drive / done / err pulse with the scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (done && err) chk("done_err_overlap", 1, 0);
      if (!bus_drv && bus != 4'h0) chk("idle_bus_zero", int'(bus), 0);
      if (bus_drv) pop_cmp(0, int'(bus));
      if (done)    pop_cmp(1, 0);
      if (err)     pop_cmp(2, 0);
    end
  end

  task automatic push(input int kind, input logic [3:0] val, input int at);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    e.at   = at;
    exp_q.push_back(e);
  endtask

  task automatic check_reg(input logic [1:0] a, input logic [3:0] exp);
    rd_addr = a;
    #1;
    chk($sformatf("reg_R%0d", a), int'(rd_data), int'(exp));
  endtask

  // Issue one command, queue its expected events, and check how long cmd_ready stays low.
  // b0..b2 are expected bus values; nbus bus cycles; is_err selects an err pulse.
  task automatic send(input logic [1:0] op, input logic [1:0] s, input logic [1:0] d,
                      input logic [3:0] imm, input int nbus, input logic [3:0] b0,
                      input logic [3:0] b1, input logic [3:0] b2, input bit is_err);
    int a;
    int n;
    int w;
    w = 0;
    @(negedge clk);
    while (!cmd_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!cmd_ready) chk("ready_timeout", 0, 1);
    cmd_op = op; cmd_src = s; cmd_dst = d; cmd_imm = imm; cmd_valid = 1'b1;
    a = cyc + 1;
    if (is_err) begin
      push(2, 4'h0, a);
    end else begin
      if (nbus > 0) push(0, b0, a);
      if (nbus > 1) push(0, b1, a + 1);
      if (nbus > 2) push(0, b2, a + 2);
      push(1, 4'h0, a + nbus);
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    n = 0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if (cmd_ready) break;
      n++;
    end
    chk("ready_low_cycles", n, is_err ? 1 : nbus + 1);
  endtask

  initial begin
    int acc [3];
    int k;
    logic [3:0] imms [3];

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_bus_drv", int'(bus_drv), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    rst = 1'b0;
    #1 chk("ready_before_edge", int'(cmd_ready), 0);
    @(posedge clk);
    #1 chk("ready_after_edge", int'(cmd_ready), 1);
    for (int i = 0; i < 4; i++) check_reg(i[1:0], 4'h0);

    // LOAD A -> R0
    send(2'b01, 2'b00, 2'b00, 4'hA, 1, 4'hA, 4'h0, 4'h0, 1'b0);
    check_reg(2'd0, 4'hA);
    // MOVE R0 -> R1
    send(2'b00, 2'b00, 2'b01, 4'h0, 1, 4'hA, 4'h0, 4'h0, 1'b0);
    check_reg(2'd1, 4'hA);
    check_reg(2'd0, 4'hA);
    // LOAD 5 -> R1, then SWAP R0,R1
    send(2'b01, 2'b00, 2'b01, 4'h5, 1, 4'h5, 4'h0, 4'h0, 1'b0);
`ifdef XFER_SWAP_EN
    send(2'b10, 2'b00, 2'b01, 4'h0, 3, 4'hA, 4'h5, 4'hA, 1'b0);
    check_reg(2'd0, 4'h5);
    check_reg(2'd1, 4'hA);
`else
    send(2'b10, 2'b00, 2'b01, 4'h0, 0, 4'h0, 4'h0, 4'h0, 1'b1);
    check_reg(2'd0, 4'hA);
    check_reg(2'd1, 4'h5);
`endif
    // LOAD 3 -> R2, MOVE R2 -> R2 (no-op with normal timing)
    send(2'b01, 2'b00, 2'b10, 4'h3, 1, 4'h3, 4'h0, 4'h0, 1'b0);
    send(2'b00, 2'b10, 2'b10, 4'h0, 1, 4'h3, 4'h0, 4'h0, 1'b0);
    check_reg(2'd2, 4'h3);
    // Reserved opcode: err pulse, no writes
    send(2'b11, 2'b10, 2'b11, 4'hF, 0, 4'h0, 4'h0, 4'h0, 1'b1);
    check_reg(2'd2, 4'h3);
    check_reg(2'd3, 4'h0);
`ifdef XFER_SWAP_EN
    // SWAP R3,R3 keeps contents, full timing
    send(2'b01, 2'b00, 2'b11, 4'h7, 1, 4'h7, 4'h0, 4'h0, 1'b0);
    send(2'b10, 2'b11, 2'b11, 4'h0, 3, 4'h7, 4'h7, 4'h7, 1'b0);
    check_reg(2'd3, 4'h7);
`endif

    // Back-to-back LOADs with cmd_valid held high
    imms[0] = 4'h1; imms[1] = 4'h2; imms[2] = 4'h3;
    k = 0;
    @(negedge clk);
    cmd_op = 2'b01; cmd_dst = 2'd0; cmd_imm = imms[0]; cmd_valid = 1'b1;
    for (int t = 0; t < 40 && k < 3; t++) begin
      if (t > 0) @(negedge clk);
      if (cmd_ready) begin
        acc[k] = cyc + 1;
        push(0, imms[k], acc[k]);
        push(1, 4'h0, acc[k] + 1);
        @(posedge clk);
        #1;
        k++;
        if (k < 3) begin
          cmd_dst = k[1:0];
          cmd_imm = imms[k];
        end else begin
          cmd_valid = 1'b0;
        end
      end
    end
    cmd_valid = 1'b0;
    chk("b2b_accepts", k, 3);
    if (k == 3) begin
      chk("b2b_spacing0", acc[1] - acc[0], 3);
      chk("b2b_spacing1", acc[2] - acc[1], 3);
    end
    repeat (3) @(negedge clk);
    check_reg(2'd0, 4'h1);
    check_reg(2'd1, 4'h2);
    check_reg(2'd2, 4'h3);

    // Reset in the middle of DRV1 of MOVE R0 -> R1
    send(2'b01, 2'b00, 2'b00, 4'hA, 1, 4'hA, 4'h0, 4'h0, 1'b0);
    @(negedge clk);
    cmd_op = 2'b00; cmd_src = 2'd0; cmd_dst = 2'd1; cmd_valid = 1'b1;
    push(0, 4'hA, cyc + 1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("rst_async_bus_drv", int'(bus_drv), 0);
    @(posedge clk);
    #1 chk("rst_ready_low", int'(cmd_ready), 0);
    for (int i = 0; i < 4; i++) check_reg(i[1:0], 4'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_ready_back", int'(cmd_ready), 1);
    for (int i = 0; i < 4; i++) check_reg(i[1:0], 4'h0);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
